// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: load/store aluop codes,
// FSM state encoding and small opcode-decode helpers.
package mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: bus byte enables and replicated store data
// for stores, lane selection plus sign/zero extension for loads.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [5:0]  i_aluop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_byte_sel;
    logic [3:0]  w_half_sel;

    // Address 0 is the most significant byte of the word.
    always_comb begin
        w_byte     = i_rdata[31:24];
        w_byte_sel = 4'b1000;
        case (i_addr_lo)
            2'b00: begin w_byte = i_rdata[31:24]; w_byte_sel = 4'b1000; end
            2'b01: begin w_byte = i_rdata[23:16]; w_byte_sel = 4'b0100; end
            2'b10: begin w_byte = i_rdata[15:8];  w_byte_sel = 4'b0010; end
            default: begin w_byte = i_rdata[7:0]; w_byte_sel = 4'b0001; end
        endcase
    end

    assign w_half     = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    assign w_half_sel = i_addr_lo[1] ? 4'b0011 : 4'b1100;

    always_comb begin
        o_sel       = 4'b0000;
        o_wdata     = 32'h0000_0000;
        o_load_data = 32'h0000_0000;
        case (i_aluop)
            OP_LB: begin
                o_sel       = w_byte_sel;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            OP_LBU: begin
                o_sel       = w_byte_sel;
                o_load_data = {24'h00_0000, w_byte};
            end
            OP_LH: begin
                o_sel       = w_half_sel;
                o_load_data = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_sel       = w_half_sel;
                o_load_data = {16'h0000, w_half};
            end
            OP_LW: begin
                o_sel       = 4'b1111;
                o_load_data = i_rdata;
            end
            OP_SB: begin
                o_sel   = w_byte_sel;
                o_wdata = {4{i_reg2[7:0]}};
            end
            OP_SH: begin
                o_sel   = w_half_sel;
                o_wdata = {2{i_reg2[15:0]}};
            end
            OP_SW: begin
                o_sel   = 4'b1111;
                o_wdata = i_reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results to write-back and runs load/store
// transfers on a req/ack data bus. Optional MEM_ALIGN_CHECK_EN adds alignment exceptions.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [5:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic        mem_cp0_reg_we,
    input  logic [4:0]  mem_cp0_reg_write_addr,
    input  logic [31:0] mem_cp0_reg_data,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_cp0_reg_we,
    output logic [4:0]  wb_cp0_reg_write_addr,
    output logic [31:0] wb_cp0_reg_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        flush,
    output logic        stallreq,
    output logic        excp_adel,
    output logic        excp_ades,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_load_data;
    logic        r_flushed;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_stall;
    logic        w_issue;
    logic        w_ack_take;
    logic        w_discard;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    mem_lane_align u_lane (
        .i_aluop     (mem_aluop),
        .i_addr_lo   (mem_mem_addr[1:0]),
        .i_reg2      (mem_reg2),
        .i_rdata     (bus_rdata),
        .o_sel       (w_sel),
        .o_wdata     (w_wdata),
        .o_load_data (w_load)
    );

    assign w_is_load  = is_load_op(mem_aluop);
    assign w_is_store = is_store_op(mem_aluop);
    assign w_is_mem   = w_is_load | w_is_store;
    // A flush seen at any point of BUSY drops the result once ack arrives.
    assign w_discard  = flush | r_flushed;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_excp_adel;
    logic r_excp_ades;

    assign w_misalign = is_misaligned(mem_aluop, mem_mem_addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_excp_adel <= 1'b0;
            r_excp_ades <= 1'b0;
        end else begin
            r_excp_adel <= (r_state == ST_IDLE) && !flush && w_misalign && w_is_load;
            r_excp_ades <= (r_state == ST_IDLE) && !flush && w_misalign && w_is_store;
        end
    end

    assign excp_adel = r_excp_adel;
    assign excp_ades = r_excp_ades;
`else
    assign w_misalign = 1'b0;
    assign excp_adel  = 1'b0;
    assign excp_ades  = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && !flush && !w_misalign) begin
                    w_next  = ST_BUSY;
                    w_stall = 1'b1;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    w_next = w_discard ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_issue    = (r_state == ST_IDLE) && (w_next == ST_BUSY);
    assign w_ack_take = (r_state == ST_BUSY) && bus_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus handshake: bus_req and every bus field stay stable from the issue
    // edge until the slave returns bus_ack; the edge sampling ack ends the transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
        end else if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {mem_mem_addr[31:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_wdata;
        end else if (w_ack_take) begin
            r_bus_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_data <= 32'h0000_0000;
            r_flushed   <= 1'b0;
        end else begin
            if (w_ack_take && !w_discard) begin
                r_load_data <= w_load;
            end
            if (r_state == ST_BUSY) begin
                r_flushed <= w_discard && !bus_ack;
            end else begin
                r_flushed <= 1'b0;
            end
        end
    end

    assign wb_wd                 = mem_wd;
    assign wb_wreg               = mem_wreg & ~w_is_store & ~w_misalign;
    assign wb_wdata              = ((r_state == ST_DONE) && w_is_load) ? r_load_data : mem_wdata;
    assign wb_whilo              = mem_whilo;
    assign wb_hi                 = mem_hi;
    assign wb_lo                 = mem_lo;
    assign wb_cp0_reg_we         = mem_cp0_reg_we;
    assign wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
    assign wb_cp0_reg_data       = mem_cp0_reg_data;

    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_sel     = r_bus_sel;
    assign bus_wdata   = r_bus_wdata;
    assign stallreq    = w_stall;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model of the expected
// per-cycle behaviour plus literal checks of the worked examples.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [5:0] OP_NOP = 6'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [5:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_write_addr;
    logic [31:0] mem_cp0_reg_data;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_write_addr;
    logic [31:0] wb_cp0_reg_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        flush;
    logic        stallreq;
    logic        excp_adel;
    logic        excp_ades;
    logic [1:0]  o_dbg_state;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_cp0_reg_we(wb_cp0_reg_we),
        .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr), .wb_cp0_reg_data(wb_cp0_reg_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .flush(flush), .stallreq(stallreq), .excp_adel(excp_adel), .excp_ades(excp_ades),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    state_t      exp_state;
    logic        exp_stall, exp_req, exp_we, exp_adel, exp_ades;
    logic [31:0] exp_addr, exp_bwdata, exp_wb_wdata;
    logic [3:0]  exp_sel;
    logic        exp_wreg_chk, exp_wdata_chk, exp_wb_wreg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_load_op(input logic [5:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    function automatic logic m_store_op(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic int m_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic m_misaligned(input logic [5:0] op, input logic [31:0] addr);
        return (addr % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [5:0] op, input logic [31:0] addr);
        int sz;
        int off;
        logic [3:0] s;
        sz  = m_size(op);
        off = int'(addr % 4) / sz * sz;
        s   = 4'b0000;
        for (int b = 0; b < sz; b++) s[3 - off - b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] reg2);
        if (m_size(op) == 1) return (reg2 & 32'hFF) * 32'h0101_0101;
        if (m_size(op) == 2) return (reg2 & 32'hFFFF) * 32'h0001_0001;
        return reg2;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int sz;
        int off;
        logic [31:0] v;
        sz  = m_size(op);
        off = int'(addr % 4) / sz * sz;
        v   = rdata >> (8 * (4 - off - sz));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == OP_LB && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == OP_LH && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(o_dbg_state), 32'(exp_state));
            chk("stallreq", 32'(stallreq), 32'(exp_stall));
            chk("bus_req", 32'(bus_req), 32'(exp_req));
            chk("excp_adel", 32'(excp_adel), 32'(exp_adel));
            chk("excp_ades", 32'(excp_ades), 32'(exp_ades));
            if (exp_req) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_sel", 32'(bus_sel), 32'(exp_sel));
                chk("bus_we", 32'(bus_we), 32'(exp_we));
                chk("bus_wdata", bus_wdata, exp_bwdata);
            end
            if (exp_wreg_chk)  chk("wb_wreg", 32'(wb_wreg), 32'(exp_wb_wreg));
            if (exp_wdata_chk) chk("wb_wdata", wb_wdata, exp_wb_wdata);
            chk("wb_wd", 32'(wb_wd), 32'(mem_wd));
            chk("wb_whilo", 32'(wb_whilo), 32'(mem_whilo));
            chk("wb_hi", wb_hi, mem_hi);
            chk("wb_lo", wb_lo, mem_lo);
            chk("wb_cp0_we", 32'(wb_cp0_reg_we), 32'(mem_cp0_reg_we));
            chk("wb_cp0_addr", 32'(wb_cp0_reg_write_addr), 32'(mem_cp0_reg_write_addr));
            chk("wb_cp0_data", wb_cp0_reg_data, mem_cp0_reg_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle_exp();
        exp_state     = ST_IDLE;
        exp_stall     = 1'b0;
        exp_req       = 1'b0;
        exp_adel      = 1'b0;
        exp_ades      = 1'b0;
        exp_wreg_chk  = 1'b1;
        exp_wb_wreg   = mem_wreg;
        exp_wdata_chk = 1'b1;
        exp_wb_wdata  = mem_wdata;
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_aluop              = OP_NOP;
            mem_wd                 = 5'($urandom_range(0, 31));
            mem_wreg               = 1'($urandom_range(0, 1));
            mem_wdata              = $urandom;
            mem_whilo              = 1'($urandom_range(0, 1));
            mem_hi                 = $urandom;
            mem_lo                 = $urandom;
            mem_mem_addr           = $urandom;
            mem_cp0_reg_we         = 1'($urandom_range(0, 1));
            mem_cp0_reg_write_addr = 5'($urandom_range(0, 31));
            mem_cp0_reg_data       = $urandom;
            set_idle_exp();
            step();
        end
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int waits, input logic flush_busy,
                         output logic [31:0] got_wb, output logic [3:0] got_sel,
                         output logic [31:0] got_bwd, output logic [31:0] got_addr,
                         output logic got_we, output int stall_cnt);
        logic ld;
        logic st;
        logic bad;
        ld  = m_load_op(op);
        st  = m_store_op(op);
        bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = m_misaligned(op, addr);
`endif
        got_wb = 32'h0; got_sel = 4'h0; got_bwd = 32'h0; got_addr = 32'h0; got_we = 1'b0;
        stall_cnt    = 0;
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wdata    = $urandom;
        mem_wreg     = 1'b1;
        bus_rdata    = rdata;
        bus_ack      = 1'b0;
        set_idle_exp();
        exp_stall     = !bad;
        exp_wreg_chk  = st || bad;
        exp_wb_wreg   = 1'b0;
        exp_wdata_chk = 1'b0;
        @(negedge clk);
        if (stallreq) stall_cnt++;
        @(posedge clk);
        #1;
        if (bad) begin
            mem_aluop = OP_NOP;
            set_idle_exp();
            exp_adel = ld;
            exp_ades = st;
            step();
            set_idle_exp();
            return;
        end
        for (int k = 0; k <= waits; k++) begin
            exp_state     = ST_BUSY;
            exp_stall     = 1'b1;
            exp_req       = 1'b1;
            exp_addr      = addr & 32'hFFFF_FFFC;
            exp_sel       = m_sel(op, addr);
            exp_we        = st;
            exp_bwdata    = m_wdata(op, reg2);
            exp_wreg_chk  = st;
            exp_wb_wreg   = 1'b0;
            exp_wdata_chk = 1'b0;
            flush   = flush_busy && (k == 0);
            bus_ack = (k == waits);
            @(negedge clk);
            if (stallreq) stall_cnt++;
            got_sel = bus_sel; got_bwd = bus_wdata; got_addr = bus_addr; got_we = bus_we;
            @(posedge clk);
            #1;
        end
        flush   = 1'b0;
        bus_ack = 1'b0;
        if (flush_busy) begin
            mem_aluop = OP_NOP;
            mem_wreg  = 1'b0;
            set_idle_exp();
            return;
        end
        exp_state     = ST_DONE;
        exp_stall     = 1'b0;
        exp_req       = 1'b0;
        exp_wreg_chk  = 1'b1;
        exp_wb_wreg   = ld;
        exp_wdata_chk = 1'b1;
        exp_wb_wdata  = ld ? m_load(op, addr, rdata) : mem_wdata;
        @(negedge clk);
        if (stallreq) stall_cnt++;
        got_wb = wb_wdata;
        @(posedge clk);
        #1;
        mem_aluop = OP_NOP;
        set_idle_exp();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] wb, bwd, addr_c;
        logic [3:0]  sel;
        logic        we;
        int          sc;

        rst = 1'b1; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        mem_wd = 5'h0; mem_wreg = 1'b0; mem_wdata = 32'h0; mem_whilo = 1'b0;
        mem_hi = 32'h0; mem_lo = 32'h0; mem_aluop = OP_NOP; mem_mem_addr = 32'h0;
        mem_reg2 = 32'h0; mem_cp0_reg_we = 1'b0; mem_cp0_reg_write_addr = 5'h0;
        mem_cp0_reg_data = 32'h0;
        #1 rst = 1'b0;
        #2;
        chk("reset_bus_req", 32'(bus_req), 32'h0);
        chk("reset_bus_we", 32'(bus_we), 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_bus_sel", 32'(bus_sel), 32'h0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        chk("reset_excp", 32'({excp_adel, excp_ades}), 32'h0);
        chk("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        idle_cycles(3);

        do_op(OP_LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lw_wb_wdata", wb, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(sc), 32'd4);
        idle_cycles(1);

        do_op(OP_LB, 32'h0000_0013, 32'h0, 32'h1122_3380, 0, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lb_sel", 32'(sel), 32'h1);
        chk("lb_wb_wdata", wb, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(sc), 32'd2);
        do_op(OP_LBU, 32'h0000_0013, 32'h0, 32'h1122_3380, 0, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lbu_wb_wdata", wb, 32'h0000_0080);

        do_op(OP_SH, 32'h0000_0006, 32'h1234_ABCD, 32'h0, 1, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("sh_we", 32'(we), 32'h1);
        chk("sh_sel", 32'(sel), 32'h3);
        chk("sh_wdata", bwd, 32'hABCD_ABCD);
        chk("sh_addr", addr_c, 32'h0000_0004);

        do_op(OP_LH, 32'h0000_0000, 32'h0, 32'h8001_2345, 0, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lh_wb_wdata", wb, 32'hFFFF_8001);
        do_op(OP_LHU, 32'h0000_0002, 32'h0, 32'h8001_A345, 1, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lhu_wb_wdata", wb, 32'h0000_A345);
        idle_cycles(2);

        do_op(OP_SB, 32'h0000_0101, 32'h0000_005A, 32'h0, 0, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("sb_sel", 32'(sel), 32'h4);
        chk("sb_wdata", bwd, 32'h5A5A_5A5A);
        do_op(OP_SW, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 3, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("sw_stall_cycles", 32'(sc), 32'd5);

        do_op(OP_LW, 32'h0000_0002, 32'h0, 32'h0BAD_CAFE, 0, 1'b0, wb, sel, bwd, addr_c, we, sc);
        chk("lw_misaligned_addr", addr_c, 32'h0000_0000);
        idle_cycles(1);

        // flush in BUSY: request held until ack, then straight to IDLE
        do_op(OP_LW, 32'h0000_0030, 32'h0, 32'h7777_7777, 2, 1'b1, wb, sel, bwd, addr_c, we, sc);
        chk("flush_busy_stall_cycles", 32'(sc), 32'd4);
        idle_cycles(2);

        // flush in IDLE: no request issued
        mem_aluop    = OP_LW;
        mem_mem_addr = 32'h0000_0044;
        flush        = 1'b1;
        set_idle_exp();
        exp_wreg_chk  = 1'b0;
        exp_wdata_chk = 1'b0;
        step();
        flush = 1'b0;
        idle_cycles(2);

        // reset during BUSY, then a late ack
        mem_aluop    = OP_LW;
        mem_mem_addr = 32'h0000_0080;
        set_idle_exp();
        exp_stall     = 1'b1;
        exp_wreg_chk  = 1'b0;
        exp_wdata_chk = 1'b0;
        step();
        chk_en = 1'b0;
        chk("pre_rst_bus_req", 32'(bus_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy_bus_req", 32'(bus_req), 32'h0);
        chk("rst_busy_state", 32'(o_dbg_state), 32'(ST_IDLE));
        chk("rst_busy_bus_addr", bus_addr, 32'h0);
        mem_aluop = OP_NOP;
        bus_ack   = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_ack_state", 32'(o_dbg_state), 32'(ST_IDLE));
            chk("late_ack_bus_req", 32'(bus_req), 32'h0);
            chk("late_ack_stallreq", 32'(stallreq), 32'h0);
            @(posedge clk);
            #1;
        end
        bus_ack = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle_cycles(2);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
